// File: rtl/key_event_led_ctrl.sv
// Key gesture classifier (click / double-click / long press)
// driving a one-hot running light with direction, speed and pause.
module key_event_led_ctrl #(
    parameter logic [25:0] LONG_CNT   = 26'd50_000_000,
    parameter logic [25:0] DCLICK_WIN = 26'd15_000_000,
    parameter logic [25:0] STEP_SLOW  = 26'd25_000_000,
    parameter logic [25:0] STEP_FAST  = 26'd12_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_flag,
    input  logic       key_value,
    output logic       click_pulse,
    output logic       dclick_pulse,
    output logic       long_pulse,
    output logic [3:0] led_on
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESSED,
        S_LONG_HELD,
        S_WAIT_2ND,
        S_PRESSED_2
    } state_t;

    state_t      r_state;
    logic        r_level;
    logic [25:0] r_hold;
    logic [25:0] r_win;
    logic [25:0] r_step;
    logic        r_click;
    logic        r_dclick;
    logic        r_long;
    logic        r_dir_left;
    logic        r_fast;
    logic        r_paused;
    logic [3:0]  r_led;

    logic        w_press;
    logic        w_release;
    logic        w_hold_end;
    logic        w_win_end;
    logic [25:0] w_period;
    logic        w_step_end;

    assign w_press    = key_flag & ~key_value & r_level;
    assign w_release  = key_flag & key_value & ~r_level;
    assign w_hold_end = (r_hold == LONG_CNT - 26'd1);
    assign w_win_end  = (r_win == DCLICK_WIN - 26'd1);
    assign w_period   = r_fast ? STEP_FAST : STEP_SLOW;
    assign w_step_end = (r_step == w_period - 26'd1);

    assign click_pulse  = r_click;
    assign dclick_pulse = r_dclick;
    assign long_pulse   = r_long;
    assign led_on       = r_led;

    // Track the debounced level so only real transitions count as edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= 1'b1;
        end else if (key_flag) begin
            r_level <= key_value;
        end
    end

    // Gesture FSM; edges take priority over timer expiry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_hold   <= '0;
            r_win    <= '0;
            r_click  <= 1'b0;
            r_dclick <= 1'b0;
            r_long   <= 1'b0;
        end else begin
            r_click  <= 1'b0;
            r_dclick <= 1'b0;
            r_long   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_press) begin
                        r_state <= S_PRESSED;
                        r_hold  <= '0;
                    end
                end
                S_PRESSED: begin
                    if (w_release) begin
                        r_state <= S_WAIT_2ND;
                        r_win   <= '0;
                    end else if (w_hold_end) begin
                        r_long  <= 1'b1;
                        r_state <= S_LONG_HELD;
                    end else begin
                        r_hold <= r_hold + 26'd1;
                    end
                end
                S_LONG_HELD: begin
                    if (w_release) begin
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT_2ND: begin
                    if (w_press) begin
                        r_state <= S_PRESSED_2;
                        r_hold  <= '0;
                    end else if (w_win_end) begin
                        r_click <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_win <= r_win + 26'd1;
                    end
                end
                S_PRESSED_2: begin
                    if (w_release) begin
                        r_dclick <= 1'b1;
                        r_state  <= S_IDLE;
                    end else if (w_hold_end) begin
                        r_dclick <= 1'b1;
                        r_state  <= S_LONG_HELD;
                    end else begin
                        r_hold <= r_hold + 26'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Mode bits toggle the cycle after their event pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dir_left <= 1'b0;
            r_fast     <= 1'b0;
            r_paused   <= 1'b0;
        end else begin
            if (r_click) r_dir_left <= ~r_dir_left;
            if (r_dclick) r_fast <= ~r_fast;
            if (r_long) r_paused <= ~r_paused;
        end
    end

    // Step timer and LED rotation; speed change restarts the period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step <= '0;
            r_led  <= 4'b0001;
        end else if (r_dclick) begin
            r_step <= '0;
        end else if (!r_paused) begin
            if (w_step_end) begin
                r_step <= '0;
                r_led  <= r_dir_left ? {r_led[2:0], r_led[3]}
                                     : {r_led[0], r_led[3:1]};
            end else begin
                r_step <= r_step + 26'd1;
            end
        end
    end

endmodule

// File: tb/tb_key_event_led_ctrl.sv
// Scoreboard bench for key_event_led_ctrl: gesture events derived
// from strobe timestamps, LED position tracked as elapsed-time arithmetic.
module tb_key_event_led_ctrl;

    localparam int LONG  = 100;
    localparam int DWIN  = 40;
    localparam int SSLOW = 20;
    localparam int SFAST = 10;
    localparam int INF   = 1 << 30;
    localparam int EV_CLICK  = 1;
    localparam int EV_DCLICK = 2;
    localparam int EV_LONG   = 3;

    typedef struct {
        int at;
        int kind;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_flag = 1'b0;
    logic       key_value = 1'b1;
    logic       click_pulse;
    logic       dclick_pulse;
    logic       long_pulse;
    logic [3:0] led_on;

    int  n_checks = 0;
    int  n_fail = 0;
    int  cyc;
    ev_t exp_q[$];
    int  ev_at[int];
    int  sched[int];

    bit  mon_en = 1'b0;
    bit  m_left, m_fast, m_paused;
    int  m_e, m_pos, m_n;

    key_event_led_ctrl #(
        .LONG_CNT  (26'd100),
        .DCLICK_WIN(26'd40),
        .STEP_SLOW (26'd20),
        .STEP_FAST (26'd10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_flag    (key_flag),
        .key_value   (key_value),
        .click_pulse (click_pulse),
        .dclick_pulse(dclick_pulse),
        .long_pulse  (long_pulse),
        .led_on      (led_on)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else cyc <= cyc + 1;
    end

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic add_ev(int kind, int at, int len);
        ev_t e;
        if (at <= len) begin
            e.at = at;
            e.kind = kind;
            exp_q.push_back(e);
            ev_at[at] = kind;
        end
    endtask

    // Events from the list of real level transitions (press, release, ...)
    task automatic classify(int len);
        int eff[$];
        int lvl, i, t, r, p2, r2;
        lvl = 1;
        foreach (sched[k]) begin
            if (sched[k] != lvl) begin
                lvl = sched[k];
                eff.push_back(k);
            end
        end
        i = 0;
        while (i < eff.size()) begin
            t = eff[i];
            r = (i + 1 < eff.size()) ? eff[i+1] : INF;
            if (r - t > LONG) begin
                add_ev(EV_LONG, t + LONG, len);
                i += 2;
            end else begin
                p2 = (i + 2 < eff.size()) ? eff[i+2] : INF;
                if (p2 - r > DWIN) begin
                    add_ev(EV_CLICK, r + DWIN, len);
                    i += 2;
                end else begin
                    r2 = (i + 3 < eff.size()) ? eff[i+3] : INF;
                    if (r2 - p2 > LONG) add_ev(EV_DCLICK, p2 + LONG, len);
                    else add_ev(EV_DCLICK, r2, len);
                    i += 4;
                end
            end
        end
    endtask

    // LED after edge n: count unpaused edges since last period restart
    task automatic model_step(int n);
        int k, p;
        k = ev_at.exists(n - 1) ? ev_at[n-1] : 0;
        p = m_fast ? SFAST : SSLOW;
        if (k == EV_DCLICK) begin
            m_e = 0;
        end else if (!m_paused) begin
            m_e++;
            if (m_e % p == 0) m_pos = m_left ? (m_pos + 1) % 4 : (m_pos + 3) % 4;
        end
        if (k == EV_CLICK) m_left = !m_left;
        if (k == EV_DCLICK) m_fast = !m_fast;
        if (k == EV_LONG) m_paused = !m_paused;
    endtask

    // Monitor: pops expected pulses and checks the running light
    always @(negedge clk) begin
        int np, seen;
        ev_t e;
        if (mon_en && rst_n) begin
            if (cyc != m_n) begin
                m_n = cyc;
                model_step(m_n);
            end
            while (exp_q.size() > 0 && exp_q[0].at < m_n) begin
                n_checks++;
                n_fail++;
                $display("FAIL missing_pulse: kind %0d required at edge %0d",
                         exp_q[0].kind, exp_q[0].at);
                void'(exp_q.pop_front());
            end
            np = int'(click_pulse) + int'(dclick_pulse) + int'(long_pulse);
            seen = click_pulse ? EV_CLICK : dclick_pulse ? EV_DCLICK :
                   long_pulse ? EV_LONG : 0;
            if (np > 0) begin
                check("single_pulse", np, 1);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", seen, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", seen, e.kind);
                    check("pulse_edge", m_n, e.at);
                end
            end
            check("led_on", int'(led_on), 1 << m_pos);
        end
    end

    task automatic run(int len);
        @(negedge clk);
        mon_en = 1'b0;
        rst_n = 1'b0;
        key_flag = 1'b0;
        key_value = 1'b1;
        #2;
        check("reset_led", int'(led_on), 1);
        check("reset_pulses", int'({click_pulse, dclick_pulse, long_pulse}), 0);
        exp_q.delete();
        ev_at.delete();
        classify(len);
        m_left = 1'b0;
        m_fast = 1'b0;
        m_paused = 1'b0;
        m_e = 0;
        m_pos = 0;
        m_n = 0;
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        for (int n = 1; n <= len; n++) begin
            if (sched.exists(n)) begin
                key_flag = 1'b1;
                key_value = sched[n][0];
            end else begin
                key_flag = 1'b0;
                key_value = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            @(negedge clk);
        end
        key_flag = 1'b0;
        #1;
        check("pending_events", exp_q.size(), 0);
    endtask

    task automatic rand_sched(int len);
        int t, lvl, v, g;
        sched.delete();
        t = 3 + int'($urandom_range(0, 10));
        lvl = 1;
        while (t < len - 5) begin
            v = ($urandom_range(0, 9) < 8) ? 1 - lvl : lvl;
            sched[t] = v;
            lvl = v;
            g = int'($urandom_range(0, 3));
            case (g)
                0: t += int'($urandom_range(1, 15));
                1: t += int'($urandom_range(DWIN - 3, DWIN + 3));
                2: t += int'($urandom_range(LONG - 3, LONG + 3));
                default: t += int'($urandom_range(1, 160));
            endcase
        end
    endtask

    initial begin
        // idle stepping
        sched.delete();
        run(60);
        // single click
        sched.delete();
        sched[5] = 0; sched[15] = 1;
        run(120);
        // double click
        sched.delete();
        sched[5] = 0; sched[15] = 1; sched[30] = 0; sched[40] = 1;
        run(120);
        // long press pauses, second long press resumes
        sched.delete();
        sched[5] = 0; sched[155] = 1; sched[200] = 0; sched[350] = 1;
        run(450);
        // redundant strobes and release racing the long terminal count
        sched.delete();
        sched[3] = 1; sched[5] = 0; sched[10] = 0; sched[105] = 1;
        run(200);
        // press cut short by reset, then stray release and a normal click
        sched.delete();
        sched[5] = 0;
        run(35);
        sched.delete();
        sched[3] = 1; sched[10] = 0; sched[20] = 1;
        run(100);
        // press landing exactly at the window terminal count
        sched.delete();
        sched[5] = 0; sched[15] = 1; sched[55] = 0; sched[60] = 1;
        run(120);
        for (int s = 0; s < 10; s++) begin
            rand_sched(600);
            run(600);
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_event_led_ctrl.md
Name: key_event_led_ctrl

Overview:
Consumer of the debounced key stream (1-cycle stable strobe plus debounced level). It classifies key activity into single-click, double-click and long-press events, and emits each as a 1-cycle pulse. It uses those events to control a 4-bit one-hot running-light pattern: direction, speed, and pause. It sits directly downstream of the key debouncer and drives the board LEDs.

Parameters:
LONG_CNT, 26'd50_000_000, hold time in clocks that qualifies a long press (1 s at 50 MHz)
DCLICK_WIN, 26'd15_000_000, window in clocks after a short release for a second press (300 ms)
STEP_SLOW, 26'd25_000_000, LED step period in clocks, slow speed (500 ms)
STEP_FAST, 26'd12_500_000, LED step period in clocks, fast speed (250 ms)
All parameters are in the range 2..2^26-1. All internal counters are 26 bits.

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous active-low reset
key_flag  input  1  1-cycle strobe: debounced level updated
key_value  input  1  debounced key level; 0 = pressed, 1 = released
click_pulse  output  1  1-cycle single-click event
dclick_pulse  output  1  1-cycle double-click event
long_pulse  output  1  1-cycle long-press event
led_on  output  4  one-hot running light

Behaviour:
- Reset (async, rst_n low):
  - FSM goes to IDLE.
  - Internal level register is set to 1.
  - Hold, window and step counters are set to 0.
  - All pulse outputs are 0.
  - led_on is 4'b0001.
  - Mode: direction = right, speed = slow, paused = 0.
- Edge detection: on key_flag=1, compare key_value against the stored level and update the stored level.
  - Press = 1→0. Release = 0→1.
  - A flag whose value equals the stored level is ignored: no state change, no pulse.
  - key_value is ignored when key_flag=0.
- FSM states:
  - IDLE: press → PRESSED, clear hold counter.
  - PRESSED: hold counter increments each cycle.
    - Release → WAIT_2ND, clear window counter.
    - Hold counter == LONG_CNT-1 → long_pulse, go to LONG_HELD.
  - LONG_HELD: release → IDLE. No pulse.
  - WAIT_2ND: window counter increments each cycle.
    - Press → PRESSED_2, clear hold counter.
    - Window counter == DCLICK_WIN-1 → click_pulse, go to IDLE.
  - PRESSED_2: hold counter increments each cycle.
    - Release → dclick_pulse, go to IDLE.
    - Hold counter == LONG_CNT-1 → dclick_pulse, go to LONG_HELD (no long_pulse).
- Priority: a key edge beats a timer expiry in the same cycle.
  - Release at expiry in PRESSED → WAIT_2ND, no long_pulse.
  - Press at expiry in WAIT_2ND → PRESSED_2, no click_pulse.
- Pulses: registered; high exactly 1 cycle, on the cycle after the qualifying edge or terminal count. At most one pulse asserts per cycle.
- Mode: updated on the clock edge after a pulse is high.
  - click_pulse toggles direction.
  - dclick_pulse toggles speed and clears the step counter.
  - long_pulse toggles paused.
- LED stepping:
  - While not paused, the step counter counts 0..P-1, where P = STEP_SLOW or STEP_FAST per the speed bit.
  - At P-1 the counter wraps to 0 and led_on rotates.
  - Right rotation: {led[0], led[3:1]}. Left rotation: {led[2:0], led[3]}.
  - While paused, the step counter holds its value and led_on holds.
  - Unpausing resumes from the held count.
- Reset mid-operation: immediate return to reset values. No pulse is generated by an edge that completes after reset release while the stored level is 1, except the normal press detection.

Test Plan (LONG_CNT=100, DCLICK_WIN=40, STEP_SLOW=20, STEP_FAST=10):
1. Release reset, no key activity → all pulses stay 0; led_on = 0001, then 1000 after 20 cycles, then 0100 after 40 cycles.
2. Press strobe (key_value=0), release strobe 10 cycles later → single click_pulse 41 cycles after release; no other pulses; subsequent steps go 0100→1000 (left).
3. Press, release after 10, press again 15 cycles later, release after 10 → exactly one dclick_pulse, no click_pulse; step interval becomes 10 cycles.
4. Press and hold 150 cycles → long_pulse exactly once, 101 cycles after the press strobe; led_on frozen; release gives no pulse. Repeat → LEDs resume stepping.
5. key_flag with key_value=1 while IDLE, and key_flag with key_value=0 while PRESSED → no state change, no pulses. Release strobe landing on hold count 99 → no long_pulse; click_pulse follows after the window.
6. Assert rst_n low 30 cycles into a press → led_on=0001 and mode reset immediately; after reset release, a release strobe gives no pulse; a normal click afterwards works as in test 2.
